fridge_status_tx: RTL and testbench

Serial status transmitter for the fridge controller. It takes a snapshot of the stored fridge/freezer temperatures, capacities and ice-maker state, then sends it as a framed UART-style byte stream to the front-panel display / service port. It is the readback end of the settings path: the controller writes the settings and this block reads them out.

---
 rtl/fridge_status_tx.sv | 155 +++++++++++++++
 tb/tb_fridge_status_tx.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fridge_status_tx.sv
// Snapshots the fridge/freezer settings and sends them as a framed 8N1 byte stream.
// Define FRIDGE_TX_CHECKSUM_EN to append an XOR checksum byte after the payload.
module fridge_status_tx #(
   parameter int CLKS_PER_BIT = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [4:0] fgt,
   input  logic [4:0] frt,
   input  logic [7:0] fgc,
   input  logic [7:0] frc,
   input  logic       ice,
   input  logic       start,
   output logic       tx,
   output logic       busy,
   output logic       done
);

   localparam logic [1:0] IDLE      = 2'd0;
   localparam logic [1:0] START_BIT = 2'd1;
   localparam logic [1:0] DATA_BITS = 2'd2;
   localparam logic [1:0] STOP_BIT  = 2'd3;

`ifdef FRIDGE_TX_CHECKSUM_EN
   localparam int NUM_BYTES = 6;
`else
   localparam int NUM_BYTES = 5;
`endif

   // A one-cycle bit still needs a 1-bit timer; it simply never leaves zero.
   localparam int                 TIMER_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(CLKS_PER_BIT - 1);
   localparam logic [2:0]         LAST_BYTE  = 3'(NUM_BYTES - 1);

   logic [1:0]         state;
   logic [TIMER_W-1:0] bit_timer;
   logic [2:0]         bit_idx;
   logic [2:0]         byte_idx;
   logic [2:0]         next_bit_idx;
   logic               bit_end;

   logic [4:0]         snap_fgt;
   logic [4:0]         snap_frt;
   logic [7:0]         snap_fgc;
   logic [7:0]         snap_frc;
   logic               snap_ice;
   logic [7:0]         cur_byte;

   assign bit_end      = (bit_timer == TIMER_LAST);
   assign next_bit_idx = bit_idx + 3'd1;

`ifdef FRIDGE_TX_CHECKSUM_EN
   logic [7:0] checksum;

   assign checksum = {snap_ice, 2'b00, snap_fgt} ^ {3'b000, snap_frt} ^ snap_fgc ^ snap_frc;
`endif

   // Byte being serialised, always taken from the snapshot so later input changes never leak in.
   always_comb begin
      cur_byte = 8'hA5;
      case (byte_idx)
         3'd0:    cur_byte = 8'hA5;
         3'd1:    cur_byte = {snap_ice, 2'b00, snap_fgt};
         3'd2:    cur_byte = {3'b000, snap_frt};
         3'd3:    cur_byte = snap_fgc;
         3'd4:    cur_byte = snap_frc;
`ifdef FRIDGE_TX_CHECKSUM_EN
         3'd5:    cur_byte = checksum;
`endif
         default: cur_byte = 8'hA5;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         bit_timer <= '0;
         bit_idx   <= '0;
         byte_idx  <= '0;
         snap_fgt  <= '0;
         snap_frt  <= '0;
         snap_fgc  <= '0;
         snap_frc  <= '0;
         snap_ice  <= 1'b0;
         tx        <= 1'b1;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            // Accepting here, including in the done cycle, lets held start give gapless frames.
            IDLE: begin
               tx   <= 1'b1;
               busy <= 1'b0;
               if (start) begin
                  snap_fgt  <= fgt;
                  snap_frt  <= frt;
                  snap_fgc  <= fgc;
                  snap_frc  <= frc;
                  snap_ice  <= ice;
                  byte_idx  <= '0;
                  bit_idx   <= '0;
                  bit_timer <= '0;
                  tx        <= 1'b0;
                  busy      <= 1'b1;
                  state     <= START_BIT;
               end
            end
            START_BIT: begin
               if (bit_end) begin
                  bit_timer <= '0;
                  bit_idx   <= '0;
                  tx        <= cur_byte[0];
                  state     <= DATA_BITS;
               end else begin
                  bit_timer <= bit_timer + TIMER_W'(1);
               end
            end
            DATA_BITS: begin
               if (bit_end) begin
                  bit_timer <= '0;
                  if (bit_idx == 3'd7) begin
                     tx    <= 1'b1;
                     state <= STOP_BIT;
                  end else begin
                     bit_idx <= next_bit_idx;
                     tx      <= cur_byte[next_bit_idx];
                  end
               end else begin
                  bit_timer <= bit_timer + TIMER_W'(1);
               end
            end
            STOP_BIT: begin
               if (bit_end) begin
                  bit_timer <= '0;
                  if (byte_idx == LAST_BYTE) begin
                     tx    <= 1'b1;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     state <= IDLE;
                  end else begin
                     byte_idx <= byte_idx + 3'd1;
                     tx       <= 1'b0;
                     state    <= START_BIT;
                  end
               end else begin
                  bit_timer <= bit_timer + TIMER_W'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fridge_status_tx.sv
// Bench for fridge_status_tx: a line decoder pops expected bytes from a scoreboard,
// and a second instance runs at one clock per bit with all inputs zero.
module tb_fridge_status_tx;

   localparam int CPB = 4;
`ifdef FRIDGE_TX_CHECKSUM_EN
   localparam int NB = 6;
`else
   localparam int NB = 5;
`endif
   localparam int FRAME_A = NB * 10 * CPB;
   localparam int FRAME_B = NB * 10;

   logic       clock;
   logic       rst;
   logic [4:0] fgt_a, frt_a;
   logic [7:0] fgc_a, frc_a;
   logic       ice_a, start_a;
   logic       tx_a, busy_a, done_a;
   logic [4:0] zero5;
   logic [7:0] zero8;
   logic       zero1, start_b;
   logic       tx_b, busy_b, done_b;

   int         checks = 0;
   int         errors = 0;
   int         cyc = 0;
   int         done_count = 0;
   int         last_done_cyc = 0;
   int         contig_left = 0;
   logic [7:0] exp_q[$];
   logic [7:0] exp_b[$];

   fridge_status_tx #(.CLKS_PER_BIT(CPB)) dut_a (
      .clk(clock), .rst(rst), .fgt(fgt_a), .frt(frt_a), .fgc(fgc_a), .frc(frc_a),
      .ice(ice_a), .start(start_a), .tx(tx_a), .busy(busy_a), .done(done_a)
   );

   fridge_status_tx #(.CLKS_PER_BIT(1)) dut_b (
      .clk(clock), .rst(rst), .fgt(zero5), .frt(zero5), .fgc(zero8), .frc(zero8),
      .ice(zero1), .start(start_b), .tx(tx_b), .busy(busy_b), .done(done_b)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input logic [4:0] g, input logic [4:0] r,
                                input logic [7:0] gc, input logic [7:0] rc, input logic i);
      fgt_a = g;
      frt_a = r;
      fgc_a = gc;
      frc_a = rc;
      ice_a = i;
   endtask

   function automatic logic [7:0] frameByte(input int idx, input logic [4:0] g, input logic [4:0] r,
                                            input logic [7:0] gc, input logic [7:0] rc, input logic i);
      logic [7:0] b1, b2;
      b1 = {i, 2'b00, g};
      b2 = {3'b000, r};
      case (idx)
         0:       return 8'hA5;
         1:       return b1;
         2:       return b2;
         3:       return gc;
         4:       return rc;
         default: return b1 ^ b2 ^ gc ^ rc;
      endcase
   endfunction

   task automatic pushFrame(input logic [4:0] g, input logic [4:0] r,
                            input logic [7:0] gc, input logic [7:0] rc, input logic i);
      for (int k = 0; k < NB; k++) exp_q.push_back(frameByte(k, g, r, gc, rc, i));
   endtask

   task automatic waitDone(input int target, input int limit, input string tag);
      int n;
      n = 0;
      while (done_count < target && n < limit) begin
         @(negedge clock);
         n++;
      end
      checkOutput(tag, done_count, target);
   endtask

   // Line decoder for instance A: samples mid-bit, checks framing, latency and gaplessness.
   initial begin : monitor_a
      int         cnt;
      int         nbytes;
      int         fall_cyc;
      logic [7:0] shift;
      logic [7:0] expv;
      cnt = -1;
      nbytes = 0;
      fall_cyc = 0;
      shift = '0;
      forever begin
         @(negedge clock);
         cyc++;
         if (rst) begin
            cnt = -1;
            nbytes = 0;
         end else begin
            if (done_a === 1'b1) begin
               done_count++;
               checkOutput("done_latency", cyc - fall_cyc, FRAME_A);
               checkOutput("bytes_per_frame", nbytes, NB);
               checkOutput("busy_at_done", {31'd0, busy_a}, 0);
               last_done_cyc = cyc;
               nbytes = 0;
            end
            if (cnt < 0) begin
               if (tx_a === 1'b0) begin
                  cnt = 0;
                  if (nbytes == 0) begin
                     fall_cyc = cyc;
                     if (contig_left > 0) begin
                        checkOutput("contiguous_start", cyc - last_done_cyc, 1);
                        contig_left--;
                     end
                  end
               end
            end else begin
               cnt++;
            end
            if (cnt >= 0) begin
               if (cnt == CPB / 2) checkOutput("start_bit", {31'd0, tx_a}, 0);
               for (int i = 0; i < 8; i++)
                  if (cnt == (i + 1) * CPB + CPB / 2) shift[i] = tx_a;
               if (cnt == 9 * CPB + CPB / 2) begin
                  checkOutput("stop_bit", {31'd0, tx_a}, 1);
                  checks++;
                  assert (exp_q.size() > 0) else begin
                     errors++;
                     $error("[TB] FAIL unexpected_byte observed=0x%0h expected=none", shift);
                  end
                  if (exp_q.size() > 0) begin
                     expv = exp_q.pop_front();
                     checkOutput("frame_byte", {24'd0, shift}, {24'd0, expv});
                  end
               end
               if (cnt == 10 * CPB - 1) begin
                  cnt = -1;
                  nbytes++;
               end
            end
         end
      end
   end

   initial begin : watchdog
      #1000000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] simulation did not finish");
   end

   initial begin : sequencer
      logic [7:0] nominal[6];
      logic [7:0] second[6];
      logic [9:0] word;
      logic [7:0] eb;
      logic       all_high;
      nominal = '{8'hA5, 8'h84, 8'h12, 8'h4B, 8'h32, 8'hEF};
      second  = '{8'hA5, 8'h9F, 8'h12, 8'h4B, 8'h32, 8'hF4};
      zero5 = '0;
      zero8 = '0;
      zero1 = 1'b0;
      start_a = 1'b0;
      start_b = 1'b0;
      applyStimulus(5'd0, 5'd0, 8'd0, 8'd0, 1'b0);
      rst = 1'b1;
      repeat (3) @(negedge clock);
      checkOutput("reset_tx", {31'd0, tx_a}, 1);
      checkOutput("reset_busy", {31'd0, busy_a}, 0);
      checkOutput("reset_done", {31'd0, done_a}, 0);
      checkOutput("reset_tx_b", {31'd0, tx_b}, 1);
      rst = 1'b0;
      repeat (2) @(negedge clock);

      $display("[TB] nominal frame with input change after snapshot");
      applyStimulus(5'd4, 5'd18, 8'd75, 8'd50, 1'b1);
      for (int k = 0; k < NB; k++) exp_q.push_back(nominal[k]);
      start_a = 1'b1;
      @(negedge clock);
      start_a = 1'b0;
      checkOutput("first_tx_low", {31'd0, tx_a}, 0);
      checkOutput("busy_high", {31'd0, busy_a}, 1);
      @(negedge clock);
      fgt_a = 5'd31;
      waitDone(1, FRAME_A + 20, "done_nominal");

      $display("[TB] next frame reports updated fridge setting");
      for (int k = 0; k < NB; k++) exp_q.push_back(second[k]);
      start_a = 1'b1;
      @(negedge clock);
      start_a = 1'b0;
      waitDone(2, FRAME_A + 20, "done_second");

      $display("[TB] start pulse while busy is ignored");
      applyStimulus(5'd10, 5'd3, 8'd200, 8'd17, 1'b0);
      pushFrame(5'd10, 5'd3, 8'd200, 8'd17, 1'b0);
      start_a = 1'b1;
      @(negedge clock);
      start_a = 1'b0;
      repeat (137) @(negedge clock);
      start_a = 1'b1;
      @(negedge clock);
      start_a = 1'b0;
      waitDone(3, FRAME_A + 20, "done_busy_ignore");
      repeat (FRAME_A) @(negedge clock);
      checkOutput("no_second_frame", done_count, 3);
      checkOutput("idle_tx", {31'd0, tx_a}, 1);
      checkOutput("queue_empty", exp_q.size(), 0);

      $display("[TB] reset during byte 2 aborts the frame");
      applyStimulus(5'd7, 5'd5, 8'd100, 8'd150, 1'b1);
      pushFrame(5'd7, 5'd5, 8'd100, 8'd150, 1'b1);
      start_a = 1'b1;
      @(negedge clock);
      start_a = 1'b0;
      repeat (82) @(negedge clock);
      checkOutput("pre_abort_tx", {31'd0, tx_a}, 0);
      #2 rst = 1'b1;
      #1;
      checkOutput("abort_tx", {31'd0, tx_a}, 1);
      checkOutput("abort_busy", {31'd0, busy_a}, 0);
      exp_q.delete();
      repeat (2) @(negedge clock);
      rst = 1'b0;
      repeat (FRAME_A) @(negedge clock);
      checkOutput("no_done_after_abort", done_count, 3);
      checkOutput("line_idle_after_abort", {31'd0, tx_a}, 1);

      $display("[TB] start held high gives back-to-back frames");
      applyStimulus(5'd20, 5'd1, 8'd33, 8'd250, 1'b1);
      for (int f = 0; f < 3; f++) pushFrame(5'd20, 5'd1, 8'd33, 8'd250, 1'b1);
      start_a = 1'b1;
      repeat (2) @(negedge clock);
      contig_left = 2;
      repeat (598) @(negedge clock);
      start_a = 1'b0;
      waitDone(6, 3 * (FRAME_A + 1) + 50, "done_back_to_back");
      checkOutput("contig_checked", contig_left, 0);
      checkOutput("queue_empty_b2b", exp_q.size(), 0);

      $display("[TB] one clock per bit, all-zero inputs");
      for (int k = 0; k < NB; k++) exp_b.push_back(frameByte(k, 5'd0, 5'd0, 8'd0, 8'd0, 1'b0));
      start_b = 1'b1;
      @(negedge clock);
      start_b = 1'b0;
      for (int m = 0; m < NB; m++) begin
         word = '0;
         for (int j = 0; j < 10; j++) begin
            word[j] = tx_b;
            @(negedge clock);
         end
         eb = exp_b.pop_front();
         checkOutput("b_byte", {22'd0, word}, {22'd0, 1'b1, eb, 1'b0});
      end
      checkOutput("b_done", {31'd0, done_b}, 1);
      checkOutput("b_busy_at_done", {31'd0, busy_b}, 0);
      all_high = 1'b1;
      for (int j = 0; j < 20; j++) begin
         @(negedge clock);
         all_high = all_high & tx_b & ~done_b;
      end
      checkOutput("b_no_extra_byte", {31'd0, all_high}, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
